// File: rtl/spi_status_tx.sv
// SPI mode-0 transmit path: one-entry word buffer shifted MSB-first on sdo, one word per cs_n frame.
// Optional build macro SPI_TX_HEADER_EN prepends header byte {4'hA, fresh, seq[2:0]} (24-bit frame).
module spi_status_tx #(
    parameter logic [15:0] IDLE_WORD = 16'h0000,
    parameter int unsigned SYNC_W    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sck,
    input  logic        cs_n,
    output logic        sdo,
    input  logic [15:0] tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic        frame_done,
    output logic        underrun
);
`ifdef SPI_TX_HEADER_EN
    localparam int unsigned FRAME_BITS = 24;
`else
    localparam int unsigned FRAME_BITS = 16;
`endif
    localparam int unsigned CNT_W = 5;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
    state_t state, state_next;

    logic [SYNC_W-1:0]     sck_sync, cs_sync;
    logic                  sck_d, cs_d;
    logic                  sck_s, cs_s, sck_rise, sck_fall, cs_fall;
    logic                  buf_full;
    logic [15:0]           buf_data;
    logic                  accept;
    logic [FRAME_BITS-1:0] shift_reg, load_word;
    logic [15:0]           word_sel;
    logic [CNT_W-1:0]      cnt;
    logic                  do_load, do_count, do_shift, do_finish;

    // cs_n synchroniser presets high so reset release never looks like a frame start
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck_sync <= '0;
            cs_sync  <= '1;
            sck_d    <= 1'b0;
            cs_d     <= 1'b1;
        end else begin
            sck_sync <= {sck_sync[SYNC_W-2:0], sck};
            cs_sync  <= {cs_sync[SYNC_W-2:0], cs_n};
            sck_d    <= sck_s;
            cs_d     <= cs_s;
        end
    end

    assign sck_s    = sck_sync[SYNC_W-1];
    assign cs_s     = cs_sync[SYNC_W-1];
    assign sck_rise = sck_s & ~sck_d;
    assign sck_fall = ~sck_s & sck_d;
    assign cs_fall  = ~cs_s & cs_d;

    assign tx_ready = ~buf_full;
    assign accept   = tx_valid & ~buf_full;
    assign word_sel = buf_full ? buf_data : IDLE_WORD;

`ifdef SPI_TX_HEADER_EN
    logic [2:0] seq;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)          seq <= '0;
        else if (do_finish) seq <= seq + 3'd1;
    end

    assign load_word = {4'hA, buf_full, seq, word_sel};
`else
    assign load_word = word_sel;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        do_load    = 1'b0;
        do_count   = 1'b0;
        do_shift   = 1'b0;
        do_finish  = 1'b0;
        case (state)
            IDLE:  if (cs_fall) state_next = LOAD;
            LOAD: begin
                do_load    = 1'b1;
                state_next = cs_s ? IDLE : SHIFT;
            end
            SHIFT: begin
                if (cs_s) begin
                    state_next = IDLE;
                end else if (cnt == CNT_W'(FRAME_BITS)) begin
                    state_next = DONE;
                    do_finish  = 1'b1;
                end else begin
                    do_count = sck_rise;
                    do_shift = sck_fall;
                end
            end
            DONE:    if (cs_s) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A load that is aborted in the same cycle still empties the buffer: the word is dropped
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_reg  <= '0;
            cnt        <= '0;
            sdo        <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
            buf_full   <= 1'b0;
            buf_data   <= '0;
        end else begin
            frame_done <= do_finish;
            underrun   <= do_load & ~buf_full;
            if (accept) begin
                buf_full <= 1'b1;
                buf_data <= tx_data;
            end
            if (do_load) begin
                if (buf_full) buf_full <= 1'b0;
                shift_reg <= load_word;
                sdo       <= load_word[FRAME_BITS-1];
                cnt       <= '0;
            end
            if (do_count) cnt <= cnt + 1'b1;
            if (do_shift) begin
                shift_reg <= shift_reg << 1;
                sdo       <= shift_reg[FRAME_BITS-2];
            end
            if (state_next == IDLE) sdo <= 1'b0;
        end
    end

endmodule
